// File: rtl/spic_master_engine_if.sv
// Instruction-fetch handshake between the spic driver and the SPI master engine.
// The engine side is the master modport; the driver side is the slave modport.
interface spic_master_engine_if #(
    parameter int INSTR_SIZE = 46,
    parameter int DWIDTH     = 32
);
    logic [INSTR_SIZE-1:0] driver_data;
    logic [1:0]            driver_cfg;
    logic                  driver_read;
    logic [DWIDTH-1:0]     spi_slv_read_data;

    modport master (
        input  driver_data,
        input  driver_cfg,
        output driver_read,
        output spi_slv_read_data
    );

    modport slave (
        output driver_data,
        output driver_cfg,
        input  driver_read,
        input  spi_slv_read_data
    );
endinterface

// File: rtl/spic_master_engine.sv
// SPI mode-0 master: fetches one instruction per transfer and shifts {T_TYPE, SIZE, ADDR, data}
// MSB first; read transfers return the captured MISO data with the following request.
//
// state | meaning
// IDLE  | waiting for master_en
// REQ   | driver_read pulse, requesting the next instruction
// LOAD  | capture instruction and divider, present first MOSI bit
// SETUP | slave selected, H cycles before the first rising sclk
// SHIFT | N bits, sclk high H / low H per bit
// HOLD  | slave still selected for H cycles after the last falling sclk
module spic_master_engine #(
    parameter int S_ADDR_WIDTH = 2,
    parameter int AWIDTH       = 8,
    parameter int DWIDTH       = 32,
    parameter int NUM_SLAVES   = 2**S_ADDR_WIDTH,
    parameter int INSTR_SIZE   = S_ADDR_WIDTH + 4 + AWIDTH + DWIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  master_en,
    spic_master_engine_if.master  drv,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SLAVES-1:0] ss_n
);
    localparam int HDR_W = 4 + AWIDTH;
    localparam int SR_W  = HDR_W + DWIDTH;
    localparam int BW    = $clog2(SR_W);

    typedef enum logic [2:0] {IDLE, REQ, LOAD, SETUP, SHIFT, HOLD} state_t;
    state_t state;

    logic [SR_W-1:0]   sr;
    logic [DWIDTH-1:0] rx;
    logic [BW-1:0]     bitcnt;
    logic [BW-1:0]     nb;
    logic [2:0]        hcnt;
    logic [2:0]        h_m1;
    logic              is_wr;

    logic [S_ADDR_WIDTH-1:0] ld_ss;
    logic [HDR_W-1:0]        ld_hdr;
    logic [DWIDTH-1:0]       ld_data;
    logic [BW-1:0]           nb_dec;
    logic [BW-1:0]           sh_amt;
    logic [2:0]              h_dec;

    always_comb begin
        ld_ss  = drv.driver_data[INSTR_SIZE-1 -: S_ADDR_WIDTH];
        ld_hdr = drv.driver_data[DWIDTH +: HDR_W];
        case (drv.driver_data[DWIDTH+AWIDTH +: 2])
            2'b00:   nb_dec = BW'(8);
            2'b01:   nb_dec = BW'(16);
            2'b10:   nb_dec = BW'(32);
            default: nb_dec = BW'(DWIDTH);
        endcase
        // write data is left-aligned so the shift register drains MSB first into trailing zeros
        sh_amt  = BW'(DWIDTH) - nb_dec;
        ld_data = drv.driver_data[DWIDTH+AWIDTH+2] ? (drv.driver_data[DWIDTH-1:0] << sh_amt) : '0;
        case (drv.driver_cfg)
            2'd0:    h_dec = 3'd0;
            2'd1:    h_dec = 3'd1;
            2'd2:    h_dec = 3'd3;
            default: h_dec = 3'd7;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            drv.driver_read       <= 1'b0;
            drv.spi_slv_read_data <= '0;
            sclk                  <= 1'b0;
            mosi                  <= 1'b0;
            ss_n                  <= '1;
            sr                    <= '0;
            rx                    <= '0;
            bitcnt                <= '0;
            nb                    <= '0;
            hcnt                  <= '0;
            h_m1                  <= '0;
            is_wr                 <= 1'b0;
        end else begin
            drv.driver_read <= 1'b0;
            case (state)
                IDLE: begin
                    if (master_en) begin
                        state           <= REQ;
                        drv.driver_read <= 1'b1;
                    end
                end
                REQ: state <= LOAD;
                LOAD: begin
                    sr     <= {ld_hdr, ld_data};
                    mosi   <= ld_hdr[HDR_W-1];
                    nb     <= nb_dec;
                    is_wr  <= drv.driver_data[DWIDTH+AWIDTH+2];
                    bitcnt <= BW'(HDR_W) + nb_dec - 1'b1;
                    h_m1   <= h_dec;
                    hcnt   <= h_dec;
                    rx     <= '0;
                    ss_n   <= ~(NUM_SLAVES'(1) << ld_ss);
                    state  <= SETUP;
                end
                SETUP: begin
                    if (hcnt == 3'd0) begin
                        state <= SHIFT;
                        sclk  <= 1'b1;
                        hcnt  <= h_m1;
                    end else begin
                        hcnt <= hcnt - 1'b1;
                    end
                end
                SHIFT: begin
                    // sample in the first high cycle; only the data bits land in rx
                    if (sclk && hcnt == h_m1 && bitcnt < nb)
                        rx <= {rx[DWIDTH-2:0], miso};
                    if (hcnt != 3'd0) begin
                        hcnt <= hcnt - 1'b1;
                    end else if (sclk) begin
                        sclk <= 1'b0;
                        hcnt <= h_m1;
                        sr   <= sr << 1;
                        mosi <= sr[SR_W-2];
                    end else if (bitcnt == '0) begin
                        state <= HOLD;
                        hcnt  <= h_m1;
                        if (!is_wr)
                            drv.spi_slv_read_data <= rx;
                    end else begin
                        bitcnt <= bitcnt - 1'b1;
                        sclk   <= 1'b1;
                        hcnt   <= h_m1;
                    end
                end
                HOLD: begin
                    if (hcnt == 3'd0) begin
                        ss_n <= '1;
                        mosi <= 1'b0;
                        if (master_en) begin
                            state           <= REQ;
                            drv.driver_read <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        hcnt <= hcnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spic_master_engine.sv
// Directed bench for spic_master_engine: back-to-back write/read transfers, enable drop,
// asynchronous reset mid-transfer and a full-width write.
module tb_spic_master_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       master_en = 1'b0;
    logic       sclk, mosi, miso;
    logic [3:0] ss_n;

    int n_cmp = 0;
    int n_bad = 0;

    spic_master_engine_if #(.INSTR_SIZE(46), .DWIDTH(32)) drv ();

    spic_master_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .master_en (master_en),
        .drv       (drv),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .ss_n      (ss_n)
    );

    always #5 clk = ~clk;

    // sclk edge monitor: pulse count, MOSI at each rising edge, H=4 phase lengths
    int          npulse = 0;
    int          nhi40 = 0;
    int          nper80 = 0;
    logic [63:0] mosi_cap = '0;
    time         t_rise = 0;

    always @(posedge sclk) begin
        npulse   <= npulse + 1;
        mosi_cap <= {mosi_cap[62:0], mosi};
        if ($time - t_rise == 80) nper80 <= nper80 + 1;
        t_rise   <= $time;
    end

    always @(negedge sclk) begin
        if ($time - t_rise == 40) nhi40 <= nhi40 + 1;
    end

    // slave: reloads on select, shifts on each sclk falling edge
    logic [63:0] slave_word = '0;
    logic [63:0] tx = '0;
    logic        ss_d = 1'b1;
    logic        sclk_d = 1'b0;
    wire         ss_all_hi = &ss_n;
    assign miso = tx[63];

    always @(posedge clk) begin
        ss_d   <= ss_all_hi;
        sclk_d <= sclk;
        if (ss_d && !ss_all_hi) tx <= slave_word;
        else if (sclk_d && !sclk) tx <= {tx[62:0], 1'b0};
    end

    task automatic wait_pulse(input int budget, output int ncyc, output logic [3:0] ss2);
        ncyc = -1;
        ss2  = 4'hx;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (i == 2) ss2 = ss_n;
            if (drv.driver_read === 1'b1) begin
                ncyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int rd_seen;
        int bad_idle;
        rst_n = 1'b0;
        master_en = 1'b0;
        drv.driver_cfg = 2'd0;
        drv.driver_data = {2'd1, 2'b01, 2'b00, 8'hA5, 32'h0000003C};
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({drv.driver_read, sclk, mosi, ss_n} !== 7'b0001111) begin
            n_bad++;
            $display("FAIL reset_outputs: got rd/sclk/mosi/ss_n=%b want 0001111",
                     {drv.driver_read, sclk, mosi, ss_n});
        end
        n_cmp++;
        if (drv.spi_slv_read_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h want 00000000", drv.spi_slv_read_data);
        end
        rst_n = 1'b1;
        rd_seen = 0;
        bad_idle = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (drv.driver_read !== 1'b0) rd_seen++;
            if (ss_n !== 4'hF || sclk !== 1'b0 || mosi !== 1'b0 || drv.spi_slv_read_data !== 32'h0)
                bad_idle++;
        end
        n_cmp++;
        if (rd_seen != 0) begin
            n_bad++;
            $display("FAIL idle_no_request: got %0d pulses want 0", rd_seen);
        end
        n_cmp++;
        if (bad_idle != 0) begin
            n_bad++;
            $display("FAIL idle_outputs: got %0d cycles off reset values want 0", bad_idle);
        end
    endtask

    task automatic test_write();
        int ncyc;
        logic [3:0] ss2;
        int p0;
        master_en = 1'b1;
        wait_pulse(10, ncyc, ss2);
        n_cmp++;
        if (ncyc != 1) begin
            n_bad++;
            $display("FAIL first_request: got cycle %0d want 1", ncyc);
        end
        p0 = npulse;
        wait_pulse(100, ncyc, ss2);
        n_cmp++;
        if (ss2 !== 4'b1101) begin
            n_bad++;
            $display("FAIL write_ss_n: got %b want 1101", ss2);
        end
        n_cmp++;
        if (ncyc != 44) begin
            n_bad++;
            $display("FAIL write_latency: got %0d want 44", ncyc);
        end
        n_cmp++;
        if (npulse - p0 != 20) begin
            n_bad++;
            $display("FAIL write_pulses: got %0d want 20", npulse - p0);
        end
        n_cmp++;
        if (mosi_cap[19:0] !== 20'h4A53C) begin
            n_bad++;
            $display("FAIL write_mosi: got %h want 4a53c", mosi_cap[19:0]);
        end
        // next instruction: read, SS=2, SIZE=01, ADDR=3C, H=4; WDATA must not appear on MOSI
        drv.driver_data = {2'd2, 2'b00, 2'b01, 8'h3C, 32'hFFFFFFFF};
        drv.driver_cfg  = 2'd2;
        slave_word      = {12'h000, 16'hBEEF, 36'h0};
    endtask

    task automatic test_read();
        int ncyc;
        logic [3:0] ss2;
        int p0, h0, q0;
        p0 = npulse;
        h0 = nhi40;
        q0 = nper80;
        wait_pulse(400, ncyc, ss2);
        n_cmp++;
        if (ss2 !== 4'b1011) begin
            n_bad++;
            $display("FAIL read_ss_n: got %b want 1011", ss2);
        end
        n_cmp++;
        if (ncyc != 234) begin
            n_bad++;
            $display("FAIL read_latency: got %0d want 234", ncyc);
        end
        n_cmp++;
        if (drv.spi_slv_read_data !== 32'h0000BEEF) begin
            n_bad++;
            $display("FAIL read_data: got %h want 0000beef", drv.spi_slv_read_data);
        end
        n_cmp++;
        if (npulse - p0 != 28) begin
            n_bad++;
            $display("FAIL read_pulses: got %0d want 28", npulse - p0);
        end
        n_cmp++;
        if (mosi_cap[27:0] !== {12'h13C, 16'h0000}) begin
            n_bad++;
            $display("FAIL read_mosi: got %h want 13c0000", mosi_cap[27:0]);
        end
        n_cmp++;
        if (nhi40 - h0 != 28 || nper80 - q0 != 27) begin
            n_bad++;
            $display("FAIL read_sclk_timing: got hi40=%0d per80=%0d want 28 27",
                     nhi40 - h0, nper80 - q0);
        end
        drv.driver_data = {2'd3, 2'b01, 2'b00, 8'h0F, 32'h000000C3};
        drv.driver_cfg  = 2'd0;
    endtask

    task automatic test_enable_drop();
        int p0;
        int rd_seen;
        int hit;
        p0 = npulse;
        hit = 0;
        for (int i = 0; i < 20 && hit == 0; i++) begin
            @(negedge clk);
            if (sclk === 1'b1) hit = 1;
        end
        master_en = 1'b0;
        for (int i = 0; i < 100 && hit == 1; i++) begin
            @(negedge clk);
            if (ss_n === 4'hF) hit = 2;
        end
        n_cmp++;
        if (hit != 2) begin
            n_bad++;
            $display("FAIL drop_reaches_idle: got stage %0d want 2", hit);
        end
        rd_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (drv.driver_read !== 1'b0) rd_seen++;
        end
        n_cmp++;
        if (rd_seen != 0) begin
            n_bad++;
            $display("FAIL drop_no_request: got %0d pulses want 0", rd_seen);
        end
        n_cmp++;
        if (npulse - p0 != 20 || mosi_cap[19:0] !== 20'h40FC3) begin
            n_bad++;
            $display("FAIL drop_completes: got pulses=%0d mosi=%h want 20 40fc3",
                     npulse - p0, mosi_cap[19:0]);
        end
        n_cmp++;
        if (drv.spi_slv_read_data !== 32'h0000BEEF) begin
            n_bad++;
            $display("FAIL write_keeps_rdata: got %h want 0000beef", drv.spi_slv_read_data);
        end
        drv.driver_data = {2'd0, 2'b00, 2'b00, 8'h11, 32'h0};
        drv.driver_cfg  = 2'd1;
        slave_word      = {12'h000, 8'h5A, 44'h0};
        master_en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (drv.driver_read !== 1'b1) begin
            n_bad++;
            $display("FAIL reenable_request: got %b want 1", drv.driver_read);
        end
        @(negedge clk);
        n_cmp++;
        if (drv.driver_read !== 1'b0) begin
            n_bad++;
            $display("FAIL request_width: got %b want 0", drv.driver_read);
        end
    endtask

    task automatic test_reset_mid();
        int hit;
        int rd_seen;
        hit = 0;
        for (int i = 0; i < 20 && hit == 0; i++) begin
            @(negedge clk);
            if (sclk === 1'b1) hit = 1;
        end
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        master_en = 1'b0;
        #1;
        n_cmp++;
        if (hit != 1 || ss_n !== 4'hF || sclk !== 1'b0 || mosi !== 1'b0 || drv.driver_read !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_pins: got hit=%0d ss_n=%b sclk=%b mosi=%b want 1 1111 0 0",
                     hit, ss_n, sclk, mosi);
        end
        n_cmp++;
        if (drv.spi_slv_read_data !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset_rdata: got %h want 00000000", drv.spi_slv_read_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (drv.driver_read !== 1'b0 || ss_n !== 4'hF) rd_seen++;
        end
        n_cmp++;
        if (rd_seen != 0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %0d bad cycles want 0", rd_seen);
        end
    endtask

    task automatic test_back_to_back();
        int ncyc;
        logic [3:0] ss2;
        int p0;
        master_en = 1'b1;
        wait_pulse(10, ncyc, ss2);
        n_cmp++;
        if (ncyc != 1) begin
            n_bad++;
            $display("FAIL restart_request: got cycle %0d want 1", ncyc);
        end
        wait_pulse(200, ncyc, ss2);
        n_cmp++;
        if (ncyc != 86 || ss2 !== 4'b1110) begin
            n_bad++;
            $display("FAIL restart_read: got latency=%0d ss_n=%b want 86 1110", ncyc, ss2);
        end
        n_cmp++;
        if (drv.spi_slv_read_data !== 32'h0000005A) begin
            n_bad++;
            $display("FAIL restart_rdata: got %h want 0000005a", drv.spi_slv_read_data);
        end
        drv.driver_data = {2'd0, 2'b01, 2'b11, 8'h00, 32'h80000001};
        drv.driver_cfg  = 2'd0;
        p0 = npulse;
        wait_pulse(200, ncyc, ss2);
        n_cmp++;
        if (ncyc != 92) begin
            n_bad++;
            $display("FAIL full_width_latency: got %0d want 92", ncyc);
        end
        n_cmp++;
        if (npulse - p0 != 44) begin
            n_bad++;
            $display("FAIL full_width_pulses: got %0d want 44", npulse - p0);
        end
        n_cmp++;
        if (mosi_cap[43:0] !== {4'b0111, 8'h00, 32'h80000001}) begin
            n_bad++;
            $display("FAIL full_width_mosi: got %h want 70080000001", mosi_cap[43:0]);
        end
        n_cmp++;
        if (drv.spi_slv_read_data !== 32'h0000005A) begin
            n_bad++;
            $display("FAIL full_width_keeps_rdata: got %h want 0000005a", drv.spi_slv_read_data);
        end
        master_en = 1'b0;
        ncyc = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (ss_n === 4'hF && sclk === 1'b0 && i > 3) begin
                ncyc = i;
                break;
            end
        end
        n_cmp++;
        if (ncyc < 0) begin
            n_bad++;
            $display("FAIL final_idle: got timeout want ss_n 1111");
        end
    endtask

    initial begin
        drv.driver_data = '0;
        drv.driver_cfg  = 2'd0;
        test_reset();
        test_write();
        test_read();
        test_enable_drop();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
